vga_sprite_engine: RTL and testbench

//  Pipelined, parametrised sprite blitter for the VGA display path. Runs on the pixel

---
 rtl/vga_pkg.sv | 8 +
 rtl/vga_sprite_addr_gen.sv | 97 +++++++++
 rtl/vga_sprite_engine.sv | 78 +++++++
 tb/tb_vga_sprite_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA display-path types and screen geometry.
package vga_pkg;
  localparam int VGA_WIDTH  = 640;
  localparam int VGA_HEIGHT = 480;

  typedef logic [7:0]  pix_t;    // {R[2:0],G[2:0],B[1:0]}
  typedef logic [10:0] coord_t;
endpackage

// File: rtl/vga_sprite_addr_gen.sv
// Sprite window, frame-latched position/enable and divide-free scaled ROM addressing.
// One registered stage: rom_addr and vis follow hc/vc by 1 clk; no backpressure.
module vga_sprite_addr_gen
  import vga_pkg::*;
#(
  parameter int IMG_W  = 175,
  parameter int IMG_H  = 175,
  parameter int ADDR_W = 15,
  parameter int SCALE  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  coord_t            hc,
  input  coord_t            vc,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              enable,
  input  coord_t            pos_x,
  input  coord_t            pos_y,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              vis
);
  localparam logic [11:0]       SPAN_X   = 12'(IMG_W * SCALE);
  localparam logic [11:0]       SPAN_Y   = 12'(IMG_H * SCALE);
  localparam logic [3:0]        SUB_LAST = 4'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  coord_t            r_sx, r_sy;
  logic              r_en;
  logic [3:0]        r_col_sub, r_row_sub;
  logic [ADDR_W-1:0] r_col_addr, r_row_base, r_rom_addr;
  logic              r_vis;

  logic [11:0]       w_x_end, w_y_end;
  logic              w_hhit, w_vhit, w_in_win, w_on_screen;
  logic              w_line_start, w_line_end;
  logic [3:0]        w_sub;
  logic [ADDR_W-1:0] w_addr;

  assign w_x_end      = {1'b0, r_sx} + SPAN_X;
  assign w_y_end      = {1'b0, r_sy} + SPAN_Y;
  assign w_hhit       = (hc >= r_sx) && ({1'b0, hc} < w_x_end);
  assign w_vhit       = (vc >= r_sy) && ({1'b0, vc} < w_y_end);
  assign w_in_win     = w_hhit && w_vhit;
  assign w_on_screen  = (hc < coord_t'(VGA_WIDTH)) && (vc < coord_t'(VGA_HEIGHT));
  assign w_line_start = w_in_win && (hc == r_sx);
  assign w_line_end   = w_in_win && ({1'b0, hc} == w_x_end - 12'd1);

  // First pixel of a line restarts from the row base without waiting a cycle.
  assign w_sub  = w_line_start ? 4'd0 : r_col_sub;
  assign w_addr = w_line_start ? r_row_base : r_col_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx       <= '0;
      r_sy       <= '0;
      r_en       <= 1'b0;
      r_col_sub  <= '0;
      r_row_sub  <= '0;
      r_col_addr <= '0;
      r_row_base <= '0;
      r_rom_addr <= '0;
      r_vis      <= 1'b0;
    end else begin
      if (frame_start) begin
        r_sx <= pos_x;
        r_sy <= pos_y;
        r_en <= enable;
      end
      if (w_in_win) begin
        r_rom_addr <= w_addr;
        if (w_sub == SUB_LAST) begin
          r_col_sub  <= 4'd0;
          r_col_addr <= w_addr + 1'b1;
        end else begin
          r_col_sub  <= w_sub + 4'd1;
          r_col_addr <= w_addr;
        end
      end
      if (frame_start) begin
        r_row_sub  <= 4'd0;
        r_row_base <= '0;
      end else if (w_line_end) begin
        if (r_row_sub == SUB_LAST) begin
          r_row_sub  <= 4'd0;
          r_row_base <= r_row_base + ROW_STEP;
        end else begin
          r_row_sub <= r_row_sub + 4'd1;
        end
      end
      r_vis <= w_in_win && !blank && r_en && w_on_screen;
    end
  end

  assign rom_addr = r_rom_addr;
  assign vis      = r_vis;
endmodule

// File: rtl/vga_sprite_engine.sv
// Sprite blitter: address gen, ROM-latency alignment, colour key, registered RGB out.
// Latency ROM_LAT+1 clk from the edge sampling hc to RGB; streaming, no backpressure.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int   IMG_W   = 175,
  parameter int   IMG_H   = 175,
  parameter int   ADDR_W  = 15,
  parameter int   SCALE   = 1,
  parameter int   ROM_LAT = 1,
  parameter bit   KEY_EN  = 1'b1,
  parameter pix_t KEY     = 8'hE3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  coord_t            hc,
  input  coord_t            vc,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              enable,
  input  coord_t            pos_x,
  input  coord_t            pos_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  pix_t              rom_data,
  output logic [2:0]        R,
  output logic [2:0]        G,
  output logic [1:0]        B,
  output logic              inside_image
);
  logic               w_vis0, w_vis, w_keyed;
  logic [ROM_LAT-1:0] r_vis_sr;
  pix_t               r_pix;
  logic               r_inside;

  vga_sprite_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .SCALE (SCALE)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .hc         (hc),
    .vc         (vc),
    .blank      (blank),
    .frame_start(frame_start),
    .enable     (enable),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .rom_addr   (rom_addr),
    .vis        (w_vis0)
  );

  // Visibility travels alongside the ROM read so it lines up with rom_data.
  assign w_vis   = r_vis_sr[ROM_LAT-1];
  assign w_keyed = KEY_EN && (rom_data == KEY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vis_sr <= '0;
      r_pix    <= '0;
      r_inside <= 1'b0;
    end else begin
      r_vis_sr[0] <= w_vis0;
      for (int i = 1; i < ROM_LAT; i++) r_vis_sr[i] <= r_vis_sr[i-1];
      if (w_vis && !w_keyed) begin
        r_pix    <= rom_data;
        r_inside <= 1'b1;
      end else begin
        r_pix    <= '0;
        r_inside <= 1'b0;
      end
    end
  end

  assign {R, G, B}    = r_pix;
  assign inside_image = r_inside;
endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed table-driven bench: three engine configurations share one scan stimulus.
module tb_vga_sprite_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hc, vc;
  logic        blank, frame_start, enable;
  logic [10:0] pos_x_a, pos_y_a, pos_x_b, pos_y_b, pos_x_c, pos_y_c;
  logic [14:0] addr_a, addr_b, addr_c;
  logic [7:0]  data_a = '0, data_b = '0, data_c = '0, c_p1 = '0, c_p2 = '0;
  logic [2:0]  r_a, g_a, r_b, g_b, r_c, g_c;
  logic [1:0]  b_a, b_b, b_c;
  logic        in_a, in_b, in_c;

  always #5 clk = ~clk;

  vga_sprite_engine u_a (
    .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .blank(blank), .frame_start(frame_start),
    .enable(enable), .pos_x(pos_x_a), .pos_y(pos_y_a), .rom_addr(addr_a), .rom_data(data_a),
    .R(r_a), .G(g_a), .B(b_a), .inside_image(in_a));
  vga_sprite_engine #(.SCALE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .blank(blank), .frame_start(frame_start),
    .enable(enable), .pos_x(pos_x_b), .pos_y(pos_y_b), .rom_addr(addr_b), .rom_data(data_b),
    .R(r_b), .G(g_b), .B(b_b), .inside_image(in_b));
  vga_sprite_engine #(.ROM_LAT(3)) u_c (
    .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .blank(blank), .frame_start(frame_start),
    .enable(enable), .pos_x(pos_x_c), .pos_y(pos_y_c), .rom_addr(addr_c), .rom_data(data_c),
    .R(r_c), .G(g_c), .B(b_c), .inside_image(in_c));

  // Sprite ROM contents: low address byte, except word 5 holds the key colour.
  function automatic logic [7:0] rom_fn(input logic [14:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (a == 15'd5) ? 8'hE3 : lo;
  endfunction

  always @(posedge clk) begin
    data_a <= rom_fn(addr_a);
    data_b <= rom_fn(addr_b);
    c_p1   <= rom_fn(addr_c);
    c_p2   <= c_p1;
    data_c <= c_p2;
  end

  typedef struct { bit vld; int x; int y; } tag_t;
  typedef struct { int ph; int d; int x; int y; int ins; int rgb; int addr; } vec_t;

  tag_t hist[6];
  vec_t vecs[$];
  int   cap_in[int], cap_rgb[int], cap_addr[int];
  int   n_tests = 0, n_fail = 0;
  int   first_in, first_rgb, rgb_at_in;

  function automatic int key(input int d, input int x, input int y);
    return d * (1 << 22) + y * 2048 + x;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input int ph, input int d, input int x, input int y,
                     input int ins, input int rgb, input int addr);
    vec_t t;
    t.ph = ph; t.d = d; t.x = x; t.y = y; t.ins = ins; t.rgb = rgb; t.addr = addr;
    vecs.push_back(t);
  endtask

  // Sample outputs at the falling edge, attribute them to the pixel that produced them, then drive.
  task automatic step(input int h, input int v, input bit fs, input bit vld);
    @(negedge clk);
    if (hist[0].vld) begin
      cap_addr[key(0, hist[0].x, hist[0].y)] = int'(addr_a);
      cap_addr[key(1, hist[0].x, hist[0].y)] = int'(addr_b);
      cap_addr[key(2, hist[0].x, hist[0].y)] = int'(addr_c);
    end
    if (hist[2].vld) begin
      cap_in [key(0, hist[2].x, hist[2].y)] = int'(in_a);
      cap_rgb[key(0, hist[2].x, hist[2].y)] = int'({r_a, g_a, b_a});
      cap_in [key(1, hist[2].x, hist[2].y)] = int'(in_b);
      cap_rgb[key(1, hist[2].x, hist[2].y)] = int'({r_b, g_b, b_b});
    end
    if (hist[4].vld) begin
      cap_in [key(2, hist[4].x, hist[4].y)] = int'(in_c);
      cap_rgb[key(2, hist[4].x, hist[4].y)] = int'({r_c, g_c, b_c});
    end
    for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
    hist[0].vld = vld; hist[0].x = h; hist[0].y = v;
    hc = 11'(h);
    vc = 11'(v);
    blank = (h >= 640) || (v >= 480);
    frame_start = fs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2047, 2047, 1'b0, 1'b0);
  endtask

  task automatic fstart();
    step(0, 0, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic scan(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) step(h, v, 1'b0, 1'b1);
  endtask

  task automatic clear_caps();
    cap_in.delete(); cap_rgb.delete(); cap_addr.delete();
  endtask

  task automatic check_phase(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].ph == ph) begin
        int    k;
        string nm;
        k  = key(vecs[i].d, vecs[i].x, vecs[i].y);
        nm = $sformatf("p%0d_d%0d_(%0d,%0d)", ph, vecs[i].d, vecs[i].x, vecs[i].y);
        chk({nm, "_captured"}, int'(cap_in.exists(k) && cap_addr.exists(k)), 1);
        if (cap_in.exists(k) && cap_addr.exists(k)) begin
          chk({nm, "_inside"}, cap_in[k], vecs[i].ins);
          chk({nm, "_rgb"}, cap_rgb[k], vecs[i].rgb);
          if (vecs[i].addr >= 0) chk({nm, "_addr"}, cap_addr[k], vecs[i].addr);
        end
      end
    end
  endtask

  initial begin
    // phase, dut(0=A scale1,1=B scale2,2=C lat3), hc, vc, inside, rgb, addr(-1 = skip)
    add(1, 0,   9, 20, 0,   0,  -1);  add(1, 0,  10, 20, 1,   0,   0);
    add(1, 0,  11, 20, 1,   1,   1);  add(1, 0,  14, 20, 1,   4,   4);
    add(1, 0,  15, 20, 0,   0,   5);  add(1, 0,  16, 20, 1,   6,   6);
    add(1, 0, 184, 20, 1, 174, 174);  add(1, 0, 185, 20, 0,   0, 174);
    add(1, 0,  10, 21, 1, 175, 175);  add(1, 0,  62, 21, 0,   0, 227);
    add(1, 0,  63, 21, 1, 228, 228);
    add(2, 1,   0,  0, 1,   0,   0);  add(2, 1,   1,  0, 1,   0,   0);
    add(2, 1,   2,  0, 1,   1,   1);  add(2, 1,   3,  0, 1,   1,   1);
    add(2, 1,  10,  0, 0,   0,   5);  add(2, 1, 349,  0, 1, 174, 174);
    add(2, 1, 350,  0, 0,   0, 174);  add(2, 1,   0,  1, 1,   0,   0);
    add(2, 1,   3,  1, 1,   1,   1);  add(2, 1,   0,  2, 1, 175, 175);
    add(2, 1,   4,  3, 1, 177, 177);  add(2, 1,   0,  4, 1,  94, 350);
    add(2, 1, 348, 349, 1, 160, 30624); add(2, 1, 349, 349, 1, 160, 30624);
    add(3, 2,  19, 30, 0,   0,  -1);  add(3, 2,  20, 30, 1,   0,   0);
    add(3, 2,  22, 30, 1,   2,   2);
    add(5, 0,  10, 21, 1, 175, 175);  add(5, 0,  12, 21, 1, 177, 177);
    add(6, 0,  10, 20, 0,   0,  -1);  add(6, 0, 299, 20, 0,   0,  -1);
    add(6, 0, 300, 20, 1,   0,   0);  add(6, 0, 301, 20, 1,   1,   1);
    add(7, 0, 301, 21, 1, 176, 176);
    add(8, 0, 300, 20, 0,   0,   0);  add(8, 0, 301, 20, 0,   0,   1);
    add(9, 0,  10, 21, 0,   0,  -1);  add(9, 0,  15, 21, 0,   0,  -1);
    add(10, 0, 10, 20, 1,   0,   0);  add(10, 0, 12, 20, 1,   2,   2);

    foreach (hist[i]) hist[i].vld = 1'b0;
    rst_n = 1'b0; hc = 11'd2047; vc = 11'd2047; blank = 1'b1; frame_start = 1'b0;
    enable = 1'b1;
    pos_x_a = 11'd10; pos_y_a = 11'd20; pos_x_b = 11'd0; pos_y_b = 11'd0;
    pos_x_c = 11'd20; pos_y_c = 11'd30;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr_a", int'(addr_a), 0);
    chk("rst_rgb_a", int'({r_a, g_a, b_a}), 0);
    chk("rst_inside_a", int'(in_a), 0);
    chk("rst_inside_c", int'(in_c), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Scale 1 basic scan, key pixels included.
    clear_caps(); fstart();
    scan(20, 8, 187); scan(21, 8, 187); idle(6);
    check_phase(1);

    // Scale 2: full rows 0..4, row-end strobes only through 348, then full last row.
    clear_caps(); fstart();
    for (int v = 0; v <= 4; v++) scan(v, 0, 351);
    for (int v = 5; v <= 348; v++) step(349, v, 1'b0, 1'b0);
    scan(349, 0, 351); idle(6);
    check_phase(2);

    // ROM latency 3: edge timing relative to the edge that samples hc=20.
    clear_caps(); fstart();
    step(18, 30, 1'b0, 1'b1); step(19, 30, 1'b0, 1'b1); step(20, 30, 1'b0, 1'b1);
    first_in = -1; first_rgb = -1; rgb_at_in = -1;
    for (int n = 1; n <= 8; n++) begin
      step(20 + n, 30, 1'b0, 1'b1);
      if (first_in < 0 && in_c) begin
        first_in  = n;
        rgb_at_in = int'({r_c, g_c, b_c});
      end
      if (first_rgb < 0 && ({r_c, g_c, b_c} != 8'h00)) first_rgb = n;
    end
    idle(6);
    chk("lat3_inside_edge", first_in, 5);
    chk("lat3_rgb_at_inside_edge", rgb_at_in, 0);
    chk("lat3_rgb_edge", first_rgb, 6);
    check_phase(3);

    // Mid-frame pos_x change is ignored until the next frame_start.
    clear_caps(); fstart();
    scan(20, 8, 186);
    pos_x_a = 11'd300;
    scan(21, 8, 20); idle(6);
    check_phase(5);
    clear_caps(); fstart();
    scan(20, 8, 12); scan(20, 298, 475); idle(6);
    check_phase(6);
    // Enable dropped mid-frame persists for the rest of the frame.
    clear_caps();
    enable = 1'b0;
    scan(21, 298, 302); idle(6);
    check_phase(7);
    clear_caps(); fstart();
    scan(20, 298, 302); idle(6);
    check_phase(8);

    // Asynchronous reset inside the sprite.
    pos_x_a = 11'd10; enable = 1'b1;
    clear_caps(); fstart();
    scan(20, 8, 50);
    chk("pre_rst_inside", int'(in_a), 1);
    chk("pre_rst_rgb", int'({r_a, g_a, b_a}), 8'h25);
    chk("pre_rst_addr", int'(addr_a), 39);
    rst_n = 1'b0;
    #1;
    chk("rst_now_inside", int'(in_a), 0);
    chk("rst_now_rgb", int'({r_a, g_a, b_a}), 0);
    chk("rst_now_addr", int'(addr_a), 0);
    foreach (hist[i]) hist[i].vld = 1'b0;
    idle(2);
    rst_n = 1'b1;
    clear_caps();
    scan(21, 8, 20); idle(6);
    check_phase(9);
    clear_caps(); fstart();
    scan(20, 8, 20); idle(6);
    check_phase(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
